qtree_stream_loader: RTL and testbench
======================================

Name: qtree_stream_loader

Overview:
- Parametrised host-side loader for dataflow tree kernels.
- Deserialises NUM_ROOTS postfix-encoded trees from an AXI-stream into the kernel heap through a write/pointer-return handshake, using an internal pointer stack.
- Once every tree is loaded, issues one Go token and the root pointers to the kernel, then captures the scalar result.
- Generalises the fixed two-root QTree wrapper: arbitrary arity, root count and stack depth, plus error detection and a proper control FSM.

Parameters:
- DATA_W, 32: leaf value / result width.
- PTR_W, 16: heap pointer width.
- ARITY, 4: children per interior node.
- NUM_ROOTS, 2: trees loaded per run.
- STACK_DEPTH, 256: pointer stack entries; power of two, at least ARITY+1.
- TOK_W = 2+DATA_W, derived: stream token width.
- REC_W = 2+max(DATA_W, ARITY*PTR_W), derived: heap record width.

Ports:
- clk  in  1  clock.
- aresetn  in  1  reset, asynchronous active-low.
- s_tdata  in  TOK_W  token: [1:0] tag (0=empty leaf, 1=value leaf, 2=node, 3=reserved); [TOK_W-1:2] value.
- s_tlast  in  1  last token of the current tree.
- s_tvalid  in  1  stream valid.
- s_tready  out  1  stream ready.
- hw_valid  out  1  heap write valid.
- hw_ready  in  1  heap write ready.
- hw_data  out  REC_W  heap record: tag, then payload.
- hp_valid  in  1  pointer return valid (no backpressure).
- hp_ptr  in  PTR_W  returned heap pointer.
- go_valid  out  1  Go token valid.
- go_ready  in  1  Go token ready.
- root_valid  out  NUM_ROOTS  per-root pointer valid.
- root_ready  in  NUM_ROOTS  per-root pointer ready.
- root_ptr  out  NUM_ROOTS*PTR_W  root pointers; root k at [k*PTR_W +: PTR_W].
- res_valid  in  1  kernel result valid.
- res_data  in  DATA_W  kernel result.
- res_ready  out  1  equals result_ready.
- result_ready  in  1  host-side result ready.
- result_data  out  DATA_W  last captured result.
- done  out  1  sticky: result captured.
- err  out  1  sticky error.
- err_code  out  2  1=stack overflow, 2=stack underflow, 3=bad tlast or reserved tag.

Behaviour:
- Reset (asynchronous, aresetn=0): FSM=LOAD; stack pointer=0; root index=0. All valid outputs 0. hw_data=0, root_ptr=0, result_data=0, done=0, err=0, err_code=0. s_tready=0 during reset.
- FSM states: LOAD, WRITE, WAITPTR, LAUNCH, RUN, FINISH, ERROR.
- LOAD:
  - s_tready=1.
  - On s_tvalid, latch tag, value and tlast; go to WRITE.
  - Tags 0 and 1: record = {tag, value zero-extended}.
  - Tag 2 with depth<ARITY: ERROR, code 2.
  - Tag 2 otherwise: record = {tag, children}; child i = stack[sp-ARITY+i], so child 0 is the earliest pushed. Pop ARITY entries.
  - Tag 3: ERROR, code 3.
- WRITE: hw_valid=1 with hw_data stable until hw_ready; then go to WAITPTR.
- WAITPTR:
  - On hp_valid, push hp_ptr. If depth==STACK_DEPTH before the push: ERROR, code 1.
  - Latched tlast=0: back to LOAD.
  - Latched tlast=1 and depth after push !=1: ERROR, code 3.
  - Latched tlast=1 and depth==1: pop into root register at root index; increment index. If index reaches NUM_ROOTS go to LAUNCH, else LOAD.
  - hp_valid in any other state is ignored.
- LAUNCH:
  - go_valid and all root_valid bits assert together.
  - Each channel drops independently on its own ready, handshake occurring the cycle valid&&ready.
  - When all channels have handshaken, go to RUN. Simultaneous readys are all accepted in one cycle.
- RUN: res_ready=result_ready. On res_valid&&result_ready, result_data<=res_data, done<=1, go to FINISH.
- FINISH and ERROR are absorbing until reset. All valids 0, s_tready=0. err=1 in ERROR.
- Latency, per leaf token: accept (1 cycle) + write handshake + pointer return. Minimum 3 cycles per token.
- Stack pointer arithmetic is modulo STACK_DEPTH; overflow is detected before wrap and never silently corrupts.
- Reset mid-operation aborts immediately. Partial trees are discarded and no Go is issued.

Optional Feature:
- Macro QTREE_LOADER_PERF_EN.
- When defined: adds outputs tok_count[31:0], a count of accepted tokens, and max_depth[$clog2(STACK_DEPTH):0], the stack high-water mark. Both reset to 0 and saturate.
- When undefined: these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- ARITY=4, NUM_ROOTS=2. Stream tree A = four tag-1 leaves 1..4, then tag-2 with tlast; tree B = single tag-1 leaf 7 with tlast. Heap returns 0x10..0x15. -> Node record children {0x10,0x11,0x12,0x13}; root_ptr[0]=0x14, root_ptr[1]=0x15; go_valid asserts.
- Same stream with hw_ready low for 5 cycles per write. -> hw_data held stable throughout; s_tready=0 while waiting; results identical.
- LAUNCH with go_ready high first and root_ready[1] 3 cycles later. -> Each valid drops only after its own handshake; RUN entered after the last.
- tag-2 after only 3 leaves. -> err=1, err_code=2, s_tready=0 thereafter.
- STACK_DEPTH=8, 9 leaves without a node. -> err_code=1 on the 9th pointer push; two leaves with tlast -> err_code=3.
- RUN with res_valid=1, res_data=42, result_ready low 4 cycles then high. -> result_data=42 and done=1 one cycle after the handshake; aresetn pulse mid-LOAD returns all outputs to reset values.

Source files
------------

// File: rtl/qtree_stream_loader.sv
// rtl/qtree_stream_loader.sv - postfix tree stream loader: pointer stack, heap write, launch and result capture
// Optional QTREE_LOADER_PERF_EN adds tok_count / max_depth performance outputs.
module qtree_stream_loader #(
  parameter int DATA_W      = 32,
  parameter int PTR_W       = 16,
  parameter int ARITY       = 4,
  parameter int NUM_ROOTS   = 2,
  parameter int STACK_DEPTH = 256,
  localparam int TOK_W      = 2 + DATA_W,
  localparam int PAY_W      = (DATA_W > ARITY * PTR_W) ? DATA_W : ARITY * PTR_W,
  localparam int REC_W      = 2 + PAY_W,
  localparam int SP_W       = $clog2(STACK_DEPTH)
) (
  input  logic                       clk,
  input  logic                       aresetn,
  input  logic [TOK_W-1:0]           s_tdata,
  input  logic                       s_tlast,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  output logic                       hw_valid,
  input  logic                       hw_ready,
  output logic [REC_W-1:0]           hw_data,
  input  logic                       hp_valid,
  input  logic [PTR_W-1:0]           hp_ptr,
  output logic                       go_valid,
  input  logic                       go_ready,
  output logic [NUM_ROOTS-1:0]       root_valid,
  input  logic [NUM_ROOTS-1:0]       root_ready,
  output logic [NUM_ROOTS*PTR_W-1:0] root_ptr,
  input  logic                       res_valid,
  input  logic [DATA_W-1:0]          res_data,
  output logic                       res_ready,
  input  logic                       result_ready,
  output logic [DATA_W-1:0]          result_data,
  output logic                       done,
  output logic                       err,
  output logic [1:0]                 err_code
`ifdef QTREE_LOADER_PERF_EN
  ,
  output logic [31:0]                tok_count,
  output logic [SP_W:0]              max_depth
`endif
);

  localparam int RI_W = (NUM_ROOTS > 1) ? $clog2(NUM_ROOTS) : 1;

  typedef enum logic [2:0] {
    S_LOAD, S_WRITE, S_WAITPTR, S_LAUNCH, S_RUN, S_FINISH, S_ERROR
  } state_t;

  state_t                state, state_nxt;
  logic [PTR_W-1:0]      stack_mem [STACK_DEPTH];
  logic [SP_W:0]         depth;
  logic [RI_W-1:0]       root_idx;
  logic                  last_q;
  logic                  go_pend;
  logic [NUM_ROOTS-1:0]  root_pend;

  logic [1:0]            tok_tag;
  logic [DATA_W-1:0]     tok_val;
  logic [SP_W-1:0]       pop_base;
  logic [PAY_W-1:0]      children;

  logic                  accept;
  logic                  push;
  logic                  root_load;
  logic                  launch_set;
  logic                  res_fire;
  logic                  err_set;
  logic [1:0]            err_code_nxt;

  assign tok_tag  = s_tdata[1:0];
  assign tok_val  = s_tdata[TOK_W-1:2];
  assign pop_base = depth[SP_W-1:0] - SP_W'(ARITY);

  // Child 0 is the earliest pushed of the top ARITY entries and lands in the low payload bits.
  always_comb begin
    children = '0;
    for (int i = 0; i < ARITY; i++) begin
      children[i*PTR_W +: PTR_W] = stack_mem[pop_base + SP_W'(i)];
    end
  end

  assign s_tready   = aresetn && (state == S_LOAD);
  assign hw_valid   = (state == S_WRITE);
  assign go_valid   = go_pend;
  assign root_valid = root_pend;
  assign res_ready  = (state == S_RUN) && result_ready;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state <= S_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    push         = 1'b0;
    root_load    = 1'b0;
    launch_set   = 1'b0;
    res_fire     = 1'b0;
    err_set      = 1'b0;
    err_code_nxt = 2'd0;
    case (state)
      S_LOAD: begin
        if (s_tvalid) begin
          if (tok_tag == 2'd3) begin
            err_set      = 1'b1;
            err_code_nxt = 2'd3;
            state_nxt    = S_ERROR;
          end else if (tok_tag == 2'd2 && depth < (SP_W+1)'(ARITY)) begin
            err_set      = 1'b1;
            err_code_nxt = 2'd2;
            state_nxt    = S_ERROR;
          end else begin
            accept    = 1'b1;
            state_nxt = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (hw_ready) state_nxt = S_WAITPTR;
      end
      S_WAITPTR: begin
        if (hp_valid) begin
          if (depth == (SP_W+1)'(STACK_DEPTH)) begin
            err_set      = 1'b1;
            err_code_nxt = 2'd1;
            state_nxt    = S_ERROR;
          end else if (!last_q) begin
            push      = 1'b1;
            state_nxt = S_LOAD;
          end else if (depth != '0) begin
            err_set      = 1'b1;
            err_code_nxt = 2'd3;
            state_nxt    = S_ERROR;
          end else begin
            // A complete tree leaves exactly its root: route it straight to the root register.
            root_load = 1'b1;
            if (root_idx == RI_W'(NUM_ROOTS - 1)) begin
              launch_set = 1'b1;
              state_nxt  = S_LAUNCH;
            end else begin
              state_nxt = S_LOAD;
            end
          end
        end
      end
      S_LAUNCH: begin
        if (((go_pend & ~go_ready) == 1'b0) && ((root_pend & ~root_ready) == '0)) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (res_valid && result_ready) begin
          res_fire  = 1'b1;
          state_nxt = S_FINISH;
        end
      end
      default: begin
        state_nxt = state;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) stack_mem[depth[SP_W-1:0]] <= hp_ptr;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      depth       <= '0;
      root_idx    <= '0;
      last_q      <= 1'b0;
      hw_data     <= '0;
      root_ptr    <= '0;
      go_pend     <= 1'b0;
      root_pend   <= '0;
      result_data <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_code    <= 2'd0;
    end else begin
      if (accept) begin
        last_q <= s_tlast;
        if (tok_tag == 2'd2) begin
          hw_data <= {tok_tag, children};
          depth   <= depth - (SP_W+1)'(ARITY);
        end else begin
          hw_data <= {tok_tag, PAY_W'(tok_val)};
        end
      end
      if (push) depth <= depth + (SP_W+1)'(1);
      if (root_load) begin
        root_ptr[root_idx*PTR_W +: PTR_W] <= hp_ptr;
        root_idx                          <= root_idx + RI_W'(1);
      end
      // Each launch channel retires on its own handshake.
      if (launch_set) begin
        go_pend   <= 1'b1;
        root_pend <= '1;
      end else if (state == S_LAUNCH) begin
        go_pend   <= go_pend & ~go_ready;
        root_pend <= root_pend & ~root_ready;
      end
      if (res_fire) begin
        result_data <= res_data;
        done        <= 1'b1;
      end
      if (err_set) begin
        err      <= 1'b1;
        err_code <= err_code_nxt;
      end
    end
  end

`ifdef QTREE_LOADER_PERF_EN
  logic tok_fire;
  assign tok_fire = s_tready && s_tvalid;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      tok_count <= '0;
      max_depth <= '0;
    end else begin
      if (tok_fire && tok_count != '1) tok_count <= tok_count + 32'd1;
      if (depth > max_depth) max_depth <= depth;
    end
  end
`endif

endmodule

// File: tb/tb_qtree_stream_loader.sv
// tb/tb_qtree_stream_loader.sv - directed vector bench for qtree_stream_loader
module tb_qtree_stream_loader;
  localparam int DATA_W      = 32;
  localparam int PTR_W       = 16;
  localparam int ARITY       = 4;
  localparam int NUM_ROOTS   = 2;
  localparam int STACK_DEPTH = 8;
  localparam int TOK_W       = 2 + DATA_W;
  localparam int REC_W       = 2 + 64;

  logic                       clk = 1'b0;
  logic                       aresetn;
  logic [TOK_W-1:0]           s_tdata;
  logic                       s_tlast;
  logic                       s_tvalid;
  logic                       s_tready;
  logic                       hw_valid;
  logic                       hw_ready;
  logic [REC_W-1:0]           hw_data;
  logic                       hp_valid;
  logic [PTR_W-1:0]           hp_ptr;
  logic                       go_valid;
  logic                       go_ready;
  logic [NUM_ROOTS-1:0]       root_valid;
  logic [NUM_ROOTS-1:0]       root_ready;
  logic [NUM_ROOTS*PTR_W-1:0] root_ptr;
  logic                       res_valid;
  logic [DATA_W-1:0]          res_data;
  logic                       res_ready;
  logic                       result_ready;
  logic [DATA_W-1:0]          result_data;
  logic                       done;
  logic                       err;
  logic [1:0]                 err_code;

  always #5 clk = ~clk;

  qtree_stream_loader #(
    .DATA_W(DATA_W), .PTR_W(PTR_W), .ARITY(ARITY),
    .NUM_ROOTS(NUM_ROOTS), .STACK_DEPTH(STACK_DEPTH)
  ) dut (
    .clk(clk), .aresetn(aresetn),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .hw_valid(hw_valid), .hw_ready(hw_ready), .hw_data(hw_data),
    .hp_valid(hp_valid), .hp_ptr(hp_ptr),
    .go_valid(go_valid), .go_ready(go_ready),
    .root_valid(root_valid), .root_ready(root_ready), .root_ptr(root_ptr),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .result_ready(result_ready), .result_data(result_data),
    .done(done), .err(err), .err_code(err_code)
  );

  typedef struct {
    logic [1:0]       tag;
    logic [31:0]      val;
    logic             last;
    logic [15:0]      ptr;
    logic [REC_W-1:0] rec;
  } tok_vec_t;

  tok_vec_t vecs [6];
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    aresetn      = 1'b0;
    s_tvalid     = 1'b0;
    s_tlast      = 1'b0;
    s_tdata      = '0;
    hw_ready     = 1'b0;
    hp_valid     = 1'b0;
    hp_ptr       = '0;
    go_ready     = 1'b0;
    root_ready   = '0;
    res_valid    = 1'b0;
    res_data     = '0;
    result_ready = 1'b0;
    #1;
    check("reset_state",
          {s_tready, hw_valid, go_valid, root_valid, res_ready, done, err, err_code,
           hw_data, root_ptr, result_data}, '0);
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_tok(input logic [1:0] tag, input logic [31:0] val, input logic last,
                          input logic [15:0] ptr, input logic [REC_W-1:0] rec, input int hold);
    int t = 0;
    while (s_tready !== 1'b1 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("s_tready_load", s_tready, 1'b1);
    s_tdata  = {val, tag};
    s_tlast  = last;
    s_tvalid = 1'b1;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    check("hw_record", {hw_valid, hw_data}, {1'b1, rec});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_stable", {hw_valid, s_tready, hw_data}, {1'b1, 1'b0, rec});
    end
    hw_ready = 1'b1;
    @(posedge clk); #1;
    hw_ready = 1'b0;
    hp_ptr   = ptr;
    hp_valid = 1'b1;
    @(posedge clk); #1;
    hp_valid = 1'b0;
  endtask

  task automatic bad_tok(input logic [1:0] tag, input logic last);
    s_tdata  = {32'd0, tag};
    s_tlast  = last;
    s_tvalid = 1'b1;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
  endtask

  task automatic leaf(input logic [31:0] v, input logic last, input logic [15:0] ptr);
    send_tok(2'd1, v, last, ptr, {2'd1, 64'(v)}, 0);
  endtask

  initial begin
    vecs[0] = '{2'd1, 32'd1, 1'b0, 16'h10, {2'd1, 64'd1}};
    vecs[1] = '{2'd1, 32'd2, 1'b0, 16'h11, {2'd1, 64'd2}};
    vecs[2] = '{2'd1, 32'd3, 1'b0, 16'h12, {2'd1, 64'd3}};
    vecs[3] = '{2'd1, 32'd4, 1'b0, 16'h13, {2'd1, 64'd4}};
    vecs[4] = '{2'd2, 32'd0, 1'b1, 16'h14, {2'd2, 16'h13, 16'h12, 16'h11, 16'h10}};
    vecs[5] = '{2'd1, 32'd7, 1'b1, 16'h15, {2'd1, 64'd7}};

    aresetn = 1'b1;
    #2;

    // Run 1: no backpressure, staggered launch, delayed result.
    do_reset();
    for (int i = 0; i < 6; i++)
      send_tok(vecs[i].tag, vecs[i].val, vecs[i].last, vecs[i].ptr, vecs[i].rec, 0);
    check("launch_start", {err, go_valid, root_valid, root_ptr}, {1'b0, 1'b1, 2'b11, 32'h0015_0014});
    go_ready = 1'b1; root_ready = 2'b01;
    @(posedge clk); #1;
    go_ready = 1'b0; root_ready = 2'b00; result_ready = 1'b1;
    check("launch_partial", {go_valid, root_valid}, {1'b0, 2'b10});
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("launch_wait", {go_valid, root_valid, res_ready}, {1'b0, 2'b10, 1'b0});
    end
    root_ready = 2'b10;
    @(posedge clk); #1;
    root_ready = 2'b00;
    check("run_entered", {go_valid, root_valid, res_ready}, {1'b0, 2'b00, 1'b1});
    result_ready = 1'b0; res_valid = 1'b1; res_data = 32'd42;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("run_wait", {res_ready, done, result_data}, {1'b0, 1'b0, 32'd0});
    end
    result_ready = 1'b1;
    #1;
    check("res_ready_follow", res_ready, 1'b1);
    @(posedge clk); #1;
    res_valid = 1'b0; result_ready = 1'b0;
    check("result_capture", {done, result_data}, {1'b1, 32'd42});
    @(posedge clk); #1;
    check("finish_idle", {done, s_tready, hw_valid, go_valid, root_valid, err},
          {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0});

    // Run 2: five-cycle write backpressure, simultaneous launch readys.
    do_reset();
    for (int i = 0; i < 6; i++)
      send_tok(vecs[i].tag, vecs[i].val, vecs[i].last, vecs[i].ptr, vecs[i].rec, 5);
    check("launch_start_bp", {err, go_valid, root_valid, root_ptr}, {1'b0, 1'b1, 2'b11, 32'h0015_0014});
    go_ready = 1'b1; root_ready = 2'b11;
    @(posedge clk); #1;
    go_ready = 1'b0; root_ready = 2'b00;
    result_ready = 1'b1; res_valid = 1'b1; res_data = 32'd99;
    #1;
    check("launch_all_one_cycle", {go_valid, root_valid, res_ready}, {1'b0, 2'b00, 1'b1});
    @(posedge clk); #1;
    res_valid = 1'b0; result_ready = 1'b0;
    check("result_capture_bp", {done, result_data}, {1'b1, 32'd99});

    // Run 3: reset mid-LOAD discards the partial tree and root index.
    do_reset();
    send_tok(vecs[0].tag, vecs[0].val, vecs[0].last, vecs[0].ptr, vecs[0].rec, 0);
    send_tok(vecs[1].tag, vecs[1].val, vecs[1].last, vecs[1].ptr, vecs[1].rec, 0);
    aresetn = 1'b0;
    #1;
    check("midload_reset",
          {s_tready, hw_valid, go_valid, root_valid, done, err, err_code, hw_data, root_ptr, result_data}, '0);
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(posedge clk); #1;
    leaf(32'd5, 1'b1, 16'h20);
    leaf(32'd6, 1'b1, 16'h21);
    check("restart_roots", {err, go_valid, root_valid, root_ptr}, {1'b0, 1'b1, 2'b11, 32'h0021_0020});

    // Node with too few children on the stack.
    do_reset();
    for (int i = 0; i < 3; i++) leaf(32'(i + 1), 1'b0, 16'(16'h40 + i));
    bad_tok(2'd2, 1'b1);
    check("underflow", {err, err_code, s_tready, hw_valid}, {1'b1, 2'd2, 1'b0, 1'b0});
    repeat (3) @(posedge clk);
    #1;
    check("underflow_sticky", {err, err_code, s_tready}, {1'b1, 2'd2, 1'b0});

    // Nine leaves into an eight-entry stack.
    do_reset();
    for (int i = 0; i < 8; i++) leaf(32'(i), 1'b0, 16'(16'h30 + i));
    check("full_no_err", {err, s_tready}, {1'b0, 1'b1});
    leaf(32'd8, 1'b0, 16'h38);
    check("overflow", {err, err_code, s_tready}, {1'b1, 2'd1, 1'b0});

    // tlast with two entries on the stack.
    do_reset();
    leaf(32'd1, 1'b0, 16'h50);
    leaf(32'd2, 1'b1, 16'h51);
    check("bad_tlast", {err, err_code, go_valid}, {1'b1, 2'd3, 1'b0});

    // Reserved tag.
    do_reset();
    bad_tok(2'd3, 1'b0);
    check("reserved_tag", {err, err_code, hw_valid}, {1'b1, 2'd3, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
